// File: rtl/cpu_types_pkg.sv
// CPU-wide types.
//   mem_state_t : memory-stage sequencer state
//   mem_req_t   : request/writeback fields captured while a miss is outstanding
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        ren;       // already resolved: 0 when wen is set
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] result;
    logic [4:0]  wsel;
    logic        regwen;
    logic        use_load;  // mem_to_reg == SEL_LOAD
    logic        halt;
  } mem_req_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Shared mux-select encodings for the datapath.
//   mem_to_reg_mux_selection : writeback source (ALU result or load data)
package data_path_muxs_pkg;

  typedef enum logic {
    SEL_RESULT = 1'b0,
    SEL_LOAD   = 1'b1
  } mem_to_reg_mux_selection;

endpackage

// File: rtl/mem_access_unit_wb_latch.sv
// mem_wb_latch: writeback register of the memory stage.
//   CLK, nRST        : clock, synchronous active-low reset
//   load             : a completion happens this cycle
//   ld_wsel/ld_wen/ld_wdat/ld_halt : fields captured on load
//   wb_valid         : one-cycle pulse after each completion
//   wb_WEN           : register-file write enable (only with wb_valid)
//   wb_wsel/wb_wdat/wb_halt : hold their value between completions
module mem_wb_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic [4:0]  ld_wsel,
  input  logic        ld_wen,
  input  logic [31:0] ld_wdat,
  input  logic        ld_halt,
  output logic        wb_valid,
  output logic        wb_WEN,
  output logic        wb_halt,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wb_valid <= 1'b0;
      wb_WEN   <= 1'b0;
      wb_halt  <= 1'b0;
      wb_wsel  <= '0;
      wb_wdat  <= '0;
    end else begin
      wb_valid <= load;
      wb_WEN   <= load & ld_wen;
      if (load) begin
        wb_wsel <= ld_wsel;
        wb_wdat <= ld_wdat;
        wb_halt <= ld_halt;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access sequencer between EX/MEM and writeback.
//   CLK, nRST       : clock, synchronous active-low reset
//   req_*           : EX/MEM register contents
//   dhit, dmemload  : cache completion and load data
//   dmemREN/WEN/addr/store : cache request
//   mem_busy        : stall upstream while a request is outstanding or halted
//   wb_*            : registered one-cycle writeback bundle
//   stall_count     : saturating count of memory-stall cycles
module mem_access_unit
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    req_valid,
  input  logic                    req_ren,
  input  logic                    req_wen,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_store,
  input  logic [31:0]             req_result,
  input  logic [4:0]              req_wsel,
  input  logic                    req_regwen,
  input  mem_to_reg_mux_selection req_mem_to_reg,
  input  logic                    req_halt,
  input  logic                    dhit,
  input  logic [31:0]             dmemload,
  output logic                    dmemREN,
  output logic                    dmemWEN,
  output logic [31:0]             dmemaddr,
  output logic [31:0]             dmemstore,
  output logic                    mem_busy,
  output logic                    wb_valid,
  output logic                    wb_WEN,
  output logic                    wb_halt,
  output logic [4:0]              wb_wsel,
  output logic [31:0]             wb_wdat,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  mem_state_t state, state_n;
  mem_req_t   lat, req_now;
  logic       access;
  logic       latch_en;
  logic       wb_load;
  mem_req_t   src;   // request fields feeding outputs/writeback this cycle

  always_comb begin
    access           = req_valid & (req_ren | req_wen);
    req_now.wen      = req_wen;
    req_now.ren      = req_ren & ~req_wen;
    req_now.addr     = req_addr;
    req_now.store    = req_store;
    req_now.result   = req_result;
    req_now.wsel     = req_wsel;
    req_now.regwen   = req_regwen;
    req_now.use_load = (req_mem_to_reg == SEL_LOAD);
    req_now.halt     = req_halt;
  end

  always_comb begin
    state_n   = state;
    latch_en  = 1'b0;
    wb_load   = 1'b0;
    mem_busy  = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    src       = req_now;

    case (state)
      IDLE: begin
        if (access) begin
          dmemREN   = req_now.ren;
          dmemWEN   = req_now.wen;
          dmemaddr  = req_addr;
          dmemstore = req_store;
          if (dhit) begin
            wb_load = 1'b1;
            if (req_halt) state_n = HALTED;
          end else begin
            mem_busy = 1'b1;
            latch_en = 1'b1;
            state_n  = WAIT;
          end
        end else if (req_valid) begin
          wb_load = 1'b1;
          if (req_halt) state_n = HALTED;
        end
      end
      WAIT: begin
        src       = lat;
        dmemREN   = lat.ren;
        dmemWEN   = lat.wen;
        dmemaddr  = lat.addr;
        dmemstore = lat.store;
        if (dhit) begin
          wb_load = 1'b1;
          state_n = lat.halt ? HALTED : IDLE;
        end else begin
          mem_busy = 1'b1;
        end
      end
      HALTED: mem_busy = 1'b1;
      default: state_n = IDLE;
    endcase

    // Reset overrides the combinational request/stall outputs.
    if (!nRST) begin
      mem_busy  = 1'b0;
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemaddr  = '0;
      dmemstore = '0;
      wb_load   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      lat         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_n;
      if (latch_en) lat <= req_now;
      if (mem_busy && state != HALTED && stall_count != '1)
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  mem_wb_latch u_wb (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (wb_load),
    .ld_wsel  (src.wsel),
    .ld_wen   (src.regwen & ~src.halt),
    .ld_wdat  (src.use_load ? dmemload : src.result),
    .ld_halt  (src.halt),
    .wb_valid (wb_valid),
    .wb_WEN   (wb_WEN),
    .wb_halt  (wb_halt),
    .wb_wsel  (wb_wsel),
    .wb_wdat  (wb_wdat)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic req_valid = 0, req_ren = 0, req_wen = 0, req_regwen = 0, req_halt = 0, dhit = 0;
  logic [31:0] req_addr = 0, req_store = 0, req_result = 0, dmemload = 0;
  logic [4:0]  req_wsel = 0;
  mem_to_reg_mux_selection req_mem_to_reg = SEL_RESULT;

  logic dmemREN, dmemWEN, mem_busy, wb_valid, wb_WEN, wb_halt;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_wsel;
  logic [15:0] stall_count;

  logic s_dmemREN, s_dmemWEN, s_mem_busy, s_wb_valid, s_wb_WEN, s_wb_halt;
  logic [31:0] s_dmemaddr, s_dmemstore, s_wb_wdat;
  logic [4:0]  s_wb_wsel;
  logic [3:0]  s_stall_count;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_result(req_result), .req_wsel(req_wsel),
    .req_regwen(req_regwen), .req_mem_to_reg(req_mem_to_reg), .req_halt(req_halt),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_busy(mem_busy), .wb_valid(wb_valid),
    .wb_WEN(wb_WEN), .wb_halt(wb_halt), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .stall_count(stall_count)
  );

  mem_access_unit #(.STALL_CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_result(req_result), .req_wsel(req_wsel),
    .req_regwen(req_regwen), .req_mem_to_reg(req_mem_to_reg), .req_halt(req_halt),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN),
    .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore), .mem_busy(s_mem_busy), .wb_valid(s_wb_valid),
    .wb_WEN(s_wb_WEN), .wb_halt(s_wb_halt), .wb_wsel(s_wb_wsel), .wb_wdat(s_wb_wdat),
    .stall_count(s_stall_count)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_halted = 0, m_pend = 0;
  logic        p_ren, p_wen, p_regwen, p_halt, p_load;
  logic [31:0] p_addr, p_store, p_result;
  logic [4:0]  p_wsel;
  logic        m_wb_valid = 0, m_wb_wen = 0, m_wb_halt = 0;
  logic [4:0]  m_wb_wsel = 0;
  logic [31:0] m_wb_wdat = 0;
  int unsigned m_cnt = 0;

  function automatic void model_comb(output logic r, output logic w, output logic [31:0] a,
                                     output logic [31:0] s, output logic b);
    r = 0; w = 0; a = 0; s = 0; b = 0;
    if (!nRST) return;
    if (m_halted) b = 1;
    else if (m_pend) begin
      r = p_ren; w = p_wen; a = p_addr; s = p_store; b = !dhit;
    end else if (req_valid && (req_ren || req_wen)) begin
      w = req_wen; r = req_ren && !req_wen; a = req_addr; s = req_store; b = !dhit;
    end
  endfunction

  task automatic complete(input logic [4:0] ws, input logic rw, input logic h,
                          input logic ld, input logic [31:0] res);
    m_wb_valid = 1;
    m_wb_wen   = rw && !h;
    m_wb_halt  = h;
    m_wb_wsel  = ws;
    m_wb_wdat  = ld ? dmemload : res;
    if (h) m_halted = 1;
  endtask

  task automatic model_step();
    logic r, w, b;
    logic [31:0] a, s;
    model_comb(r, w, a, s, b);
    if (!nRST) begin
      m_halted = 0; m_pend = 0; m_cnt = 0;
      m_wb_valid = 0; m_wb_wen = 0; m_wb_halt = 0; m_wb_wsel = 0; m_wb_wdat = 0;
      return;
    end
    if (b && !m_halted) m_cnt++;
    m_wb_valid = 0;
    m_wb_wen   = 0;
    if (m_halted) begin
    end else if (m_pend) begin
      if (dhit) begin
        complete(p_wsel, p_regwen, p_halt, p_load, p_result);
        m_pend = 0;
      end
    end else if (req_valid && (req_ren || req_wen)) begin
      if (dhit) complete(req_wsel, req_regwen, req_halt, req_mem_to_reg == SEL_LOAD, req_result);
      else begin
        m_pend = 1;
        p_ren = req_ren && !req_wen; p_wen = req_wen; p_addr = req_addr; p_store = req_store;
        p_result = req_result; p_wsel = req_wsel; p_regwen = req_regwen; p_halt = req_halt;
        p_load = (req_mem_to_reg == SEL_LOAD);
      end
    end else if (req_valid) begin
      complete(req_wsel, req_regwen, req_halt, req_mem_to_reg == SEL_LOAD, req_result);
    end
  endtask

  always @(posedge CLK) model_step();

  always @(negedge CLK) begin
    logic r, w, b;
    logic [31:0] a, s;
    model_comb(r, w, a, s, b);
    chk("dmemREN", {31'b0, dmemREN}, {31'b0, r});
    chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, w});
    chk("dmemaddr", dmemaddr, a);
    chk("dmemstore", dmemstore, s);
    chk("mem_busy", {31'b0, mem_busy}, {31'b0, b});
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, m_wb_valid});
    chk("wb_WEN", {31'b0, wb_WEN}, {31'b0, m_wb_wen});
    chk("wb_halt", {31'b0, wb_halt}, {31'b0, m_wb_halt});
    chk("wb_wsel", {27'b0, wb_wsel}, {27'b0, m_wb_wsel});
    chk("wb_wdat", wb_wdat, m_wb_wdat);
    chk("stall_count", {16'b0, stall_count}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    chk("w4_dmemWEN", {31'b0, s_dmemWEN}, {31'b0, w});
    chk("w4_mem_busy", {31'b0, s_mem_busy}, {31'b0, b});
    chk("w4_wb_valid", {31'b0, s_wb_valid}, {31'b0, m_wb_valid});
    chk("w4_wb_wdat", s_wb_wdat, m_wb_wdat);
    chk("w4_stall_count", {28'b0, s_stall_count}, (m_cnt > 15) ? 32'd15 : m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic idle_in();
    req_valid = 0; req_ren = 0; req_wen = 0; req_halt = 0; dhit = 0;
    req_regwen = 0; req_mem_to_reg = SEL_RESULT;
  endtask

  initial begin
    next(); next();
    nRST = 1;
    neg();
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_stall", {16'b0, stall_count}, 32'd0);
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);

    // load hit in the request cycle
    next();
    req_valid = 1; req_ren = 1; req_addr = 32'h100; req_wsel = 5; req_regwen = 1;
    req_mem_to_reg = SEL_LOAD; dhit = 1; dmemload = 32'hDEADBEEF;
    neg();
    chk("t1_ren", {31'b0, dmemREN}, 32'd1);
    chk("t1_addr", dmemaddr, 32'h100);
    chk("t1_busy", {31'b0, mem_busy}, 32'd0);
    next(); idle_in();
    neg();
    chk("t1_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t1_wb_wsel", {27'b0, wb_wsel}, 32'd5);
    chk("t1_wb_wdat", wb_wdat, 32'hDEADBEEF);
    chk("t1_stall", {16'b0, stall_count}, 32'd0);

    // store miss, dhit on the 4th cycle, inputs change meanwhile
    next();
    req_valid = 1; req_wen = 1; req_addr = 32'h200; req_store = 32'h12345678; req_regwen = 0;
    neg();
    chk("t2_wen0", {31'b0, dmemWEN}, 32'd1);
    chk("t2_busy0", {31'b0, mem_busy}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      next();
      req_addr = $urandom; req_store = $urandom; req_wen = 0; req_ren = 1;
      neg();
      chk("t2_wen", {31'b0, dmemWEN}, 32'd1);
      chk("t2_ren", {31'b0, dmemREN}, 32'd0);
      chk("t2_addr", dmemaddr, 32'h200);
      chk("t2_store", dmemstore, 32'h12345678);
      chk("t2_busy", {31'b0, mem_busy}, 32'd1);
    end
    next(); dhit = 1;
    neg();
    chk("t2_busy_hit", {31'b0, mem_busy}, 32'd0);
    chk("t2_addr_hit", dmemaddr, 32'h200);
    next(); idle_in();
    neg();
    chk("t2_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t2_wb_WEN", {31'b0, wb_WEN}, 32'd0);
    chk("t2_stall", {16'b0, stall_count}, 32'd3);

    // ALU op
    next();
    req_valid = 1; req_result = 32'h55; req_regwen = 1; req_wsel = 8; dhit = 0;
    neg();
    chk("t3_ren", {31'b0, dmemREN}, 32'd0);
    chk("t3_wen", {31'b0, dmemWEN}, 32'd0);
    chk("t3_addr", dmemaddr, 32'd0);
    next(); idle_in();
    neg();
    chk("t3_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t3_wb_WEN", {31'b0, wb_WEN}, 32'd1);
    chk("t3_wb_wdat", wb_wdat, 32'h55);
    chk("t3_wb_wsel", {27'b0, wb_wsel}, 32'd8);

    // halt
    next();
    req_valid = 1; req_halt = 1; req_regwen = 1;
    neg();
    next(); idle_in();
    neg();
    chk("t4_wb_halt", {31'b0, wb_halt}, 32'd1);
    chk("t4_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t4_wb_WEN", {31'b0, wb_WEN}, 32'd0);
    chk("t4_busy", {31'b0, mem_busy}, 32'd1);
    next();
    req_valid = 1; req_ren = 1; req_addr = 32'h300; dhit = 1;
    neg();
    chk("t4_ren_halted", {31'b0, dmemREN}, 32'd0);
    chk("t4_addr_halted", dmemaddr, 32'd0);
    next(); idle_in();
    neg();
    chk("t4_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("t4_stall", {16'b0, stall_count}, 32'd3);
    next(); nRST = 0;
    neg();
    chk("t4_busy_rst", {31'b0, mem_busy}, 32'd0);
    next(); nRST = 1;
    neg();
    chk("t4_wb_halt_clr", {31'b0, wb_halt}, 32'd0);
    chk("t4_stall_clr", {16'b0, stall_count}, 32'd0);

    // reset during WAIT
    next();
    req_valid = 1; req_ren = 1; req_addr = 32'h400; req_wsel = 3; req_regwen = 1;
    req_mem_to_reg = SEL_LOAD; dhit = 0;
    neg(); next(); neg();
    next(); nRST = 0;
    neg();
    chk("t5_ren_rst", {31'b0, dmemREN}, 32'd0);
    next(); nRST = 1; idle_in(); dhit = 1;
    neg();
    chk("t5_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("t5_stall", {16'b0, stall_count}, 32'd0);
    next();
    req_valid = 1; req_ren = 1; req_addr = 32'h500; req_mem_to_reg = SEL_LOAD; dhit = 1;
    neg();
    chk("t5_no_wb2", {31'b0, wb_valid}, 32'd0);
    chk("t5_idle_addr", dmemaddr, 32'h500);
    chk("t5_idle_busy", {31'b0, mem_busy}, 32'd0);
    next(); idle_in();
    neg();
    chk("t5_wb_valid", {31'b0, wb_valid}, 32'd1);

    // read/write conflict and saturation of the 4-bit counter
    next(); nRST = 0;
    next(); nRST = 1;
    req_valid = 1; req_ren = 1; req_wen = 1; req_addr = 32'h600; req_store = 32'hA5; dhit = 0;
    neg();
    chk("t6_w4_wen", {31'b0, s_dmemWEN}, 32'd1);
    chk("t6_w4_ren", {31'b0, s_dmemREN}, 32'd0);
    for (int i = 1; i < 20; i++) begin
      next(); neg();
    end
    next(); dhit = 1;
    neg();
    chk("t6_w4_sat", {28'b0, s_stall_count}, 32'd15);
    chk("t6_stall20", {16'b0, stall_count}, 32'd20);
    next(); idle_in();
    neg();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next();
      nRST = m_halted ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) != 0);
      req_valid = $urandom_range(0, 3) != 0;
      req_ren = $urandom_range(0, 1);
      req_wen = $urandom_range(0, 2) == 0;
      req_halt = $urandom_range(0, 31) == 0;
      req_addr = $urandom; req_store = $urandom; req_result = $urandom; dmemload = $urandom;
      req_wsel = 5'($urandom); req_regwen = $urandom_range(0, 1);
      req_mem_to_reg = mem_to_reg_mux_selection'($urandom_range(0, 1));
      dhit = $urandom_range(0, 2) == 0;
    end
    next(); idle_in();
    neg();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access sequencer between the EX/MEM pipeline register and the register-file writeback. It issues one data-cache request per memory instruction and holds it until `dhit`. While a request is outstanding it stalls the upstream pipeline. On completion it registers a one-cycle writeback bundle, handles halt draining, and counts memory-stall cycles.

## Interface
Parameters:
- `STALL_CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `nRST`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: the EX/MEM register holds a live instruction.
- `req_ren`, `req_wen`  in  1 each: load and store request from EX/MEM.
- `req_addr`  in  32: data address (ALU result).
- `req_store`  in  32: store data.
- `req_result`  in  32: ALU result used for non-load writeback.
- `req_wsel`  in  5: destination register.
- `req_regwen`  in  1: instruction writes the register file.
- `req_mem_to_reg`  in  `mem_to_reg_mux_selection`: `SEL_RESULT` or `SEL_LOAD`.
- `req_halt`  in  1: halt instruction.
- `dhit`  in  1: cache completes the current request.
- `dmemload`  in  32: load data, valid when `dhit`.
- `dmemREN`, `dmemWEN`  out  1 each: cache request.
- `dmemaddr`, `dmemstore`  out  32 each.
- `mem_busy`  out  1: stall upstream; EX/MEM must hold its contents stable while high.
- `wb_valid`, `wb_WEN`, `wb_halt`  out  1 each.
- `wb_wsel`  out  5.
- `wb_wdat`  out  32.
- `stall_count`  out  `STALL_CNT_W`.

## Operation
- Access detection: `access = req_valid & (req_ren | req_wen)`. If both are set, the request is a write: `dmemWEN=1`, `dmemREN=0`.
- FSM states are `IDLE`, `WAIT` and `HALTED`.
- `IDLE`:
  - The `dmem*` outputs are a combinational pass-through of the `req_*` inputs, gated by `access`. When there is no access, all four outputs are 0.
  - `access & dhit`: complete this cycle; stay in `IDLE`.
  - `access & !dhit`: latch the request and writeback fields, then go to `WAIT`.
  - `req_valid & !access & !req_halt`: complete as a non-memory instruction.
  - `req_valid & req_halt` (no access): go to `HALTED`.
- `WAIT`:
  - The `dmem*` outputs come from the latched request and ignore the `req_*` inputs.
  - On `dhit`: complete, then return to `IDLE`.
- `HALTED`:
  - All `dmem*` outputs are 0, `mem_busy=1` and `wb_halt=1`. All inputs are ignored.
  - Only reset leaves this state.
- `mem_busy = (IDLE & access & !dhit) | WAIT | HALTED`, with `WAIT` contributing only while `!dhit`. The cycle in which `dhit` arrives has `mem_busy=0`.
- Completion: on the next edge the WB register loads the following, with `wb_valid=1` for exactly one cycle:
  - `wb_wsel` = request `wsel`.
  - `wb_WEN = regwen`.
  - `wb_wdat` = `dmemload` if `mem_to_reg == SEL_LOAD`, else `result`.
- Cycles with no completion: `wb_valid=0` and `wb_WEN=0`. `wb_wsel` and `wb_wdat` hold their previous values.
- Halt:
  - A halt instruction produces a completion with `wb_halt=1` and `wb_WEN=0`, then enters `HALTED`.
  - A halt cannot coexist with an access; the decoder guarantees this. If both appear, the access is served and the halt proceeds as above.
- Stall counter: `stall_count` increments on every edge where `mem_busy=1` and the state is not `HALTED`. It saturates at all-ones.

## Timing
- Reset (`nRST=0` at an edge):
  - State goes to `IDLE`.
  - `wb_valid`, `wb_WEN`, `wb_halt`, `wb_wsel`, `wb_wdat` and `stall_count` become 0.
  - While `nRST=0`, `dmemREN`, `dmemWEN`, `dmemaddr`, `dmemstore` and `mem_busy` are forced to 0.
- Reset mid-`WAIT` abandons the outstanding request. No writeback is produced.
- Hit on the first cycle: writeback is visible 1 cycle after the request cycle, with 0 stall cycles.
- Miss with `dhit` arriving N cycles after the request:
  - `mem_busy` is high for N cycles.
  - Writeback is visible on the edge after `dhit`.
  - `stall_count` increases by N.
- Back-to-back: a new request can be presented in the cycle after a completion. There are no bubble cycles.
- `dhit` is ignored in `IDLE` when there is no access, and in `HALTED`.

## Structure
- Add `mem_state_t` (`IDLE`, `WAIT`, `HALTED`) to `cpu_types_pkg`.
- Reuse `mem_to_reg_mux_selection` from `data_path_muxs_pkg`.
- One sub-module, `mem_wb_latch`: the writeback register with its load enable and one-cycle `wb_valid` pulse.
- The FSM, request latch and counter live in the top module.

## Test plan
- Load hit in the same cycle:
  - Stimulus: `req_ren=1`, `addr=0x100`, `wsel=5`, `SEL_LOAD`, `dhit=1`, `dmemload=0xDEADBEEF`.
  - Required: `dmemREN=1`, `dmemaddr=0x100`, `mem_busy=0`. Next cycle `wb_valid=1`, `wb_wsel=5`, `wb_wdat=0xDEADBEEF`. `stall_count=0`.
- Store miss for 3 cycles:
  - Stimulus: `req_wen=1`, `addr=0x200`, `store=0x12345678`; change the `req_*` inputs after the first cycle; `dhit` arrives on the 4th cycle.
  - Required: `dmemWEN`/`addr`/`store` hold their original values throughout. `mem_busy` is high for 3 cycles. Then `wb_valid=1`, `wb_WEN=0`, and `stall_count=3`.
- ALU op:
  - Stimulus: `req_valid=1`, no `ren`/`wen`, `result=0x55`, `regwen=1`, `wsel=8`.
  - Required: `dmem*` outputs = 0. Next cycle `wb_valid=1`, `wb_WEN=1`, `wb_wdat=0x55`.
- Halt:
  - Stimulus: `req_valid=1`, `req_halt=1`.
  - Required: next cycle `wb_halt=1`, `wb_valid=1`, `wb_WEN=0`. `mem_busy=1` thereafter; later requests with `dhit` produce no `dmem` activity. Reset returns to `IDLE` with `wb_halt=0`.
- Reset in `WAIT`:
  - Stimulus: load miss; assert `nRST=0` on the 2nd wait cycle; `dhit=1` after reset.
  - Required: no writeback occurs. `stall_count=0` and the state is `IDLE`.
- Conflict and saturation, with `STALL_CNT_W=4`:
  - Stimulus: `ren=wen=1`, then hold a miss for 20 cycles.
  - Required: `dmemWEN=1`, `dmemREN=0`, and `stall_count` saturates at 15.
